// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
//  Shared types and helpers for the column-serial AES datapath.
//   byte_t / col_t / state_t : byte, 32-bit column and 128-bit state words
//   ser_state_e              : serializer FSM states
//   sr_src()                 : (Inv)ShiftRows source byte index for out col/row
//   gf_mul() / gf_inv()      : GF(2^8) arithmetic used by the S-box
// ----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  col_t;
    typedef logic [127:0] state_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ser_state_e;

    // Output row r of output column c reads input byte 4*src_col + r.
    // Forward ShiftRows rotates row r left by r, so src_col = c + r (mod 4);
    // the inverse rotates right, so src_col = c - r (mod 4). The 2-bit
    // arithmetic wraps mod 4 for free, and {src_col, r} == 4*src_col + r.
    function automatic logic [3:0] sr_src(input logic [1:0] c,
                                          input logic [1:0] r,
                                          input logic       inv);
        logic [1:0] src_col;
        src_col = inv ? (c - r) : (c + r);
        return {src_col, r};
    endfunction

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t acc;
        byte_t aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (x^-1 in GF(2^8)); maps 0 to 0, which is
    // exactly what the S-box definition needs.
    // 254 = 2+4+8+16+32+64+128, so accumulate successive squares.
    function automatic byte_t gf_inv(input byte_t x);
        byte_t sq;
        byte_t acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage : aes_pkg

// File: rtl/aes_sbox.sv
// ----------------------------------------------------------------------------
// aes_sbox
//  Combinational AES S-box (INV=0) or inverse S-box (INV=1), computed from the
//  GF(2^8) inverse plus the affine transform rather than a lookup table.
//  Ports:
//   i_byte  in  8  input byte
//   o_byte  out 8  substituted byte
// ----------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
#(
    parameter bit INV = 1'b0
) (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic byte_t rotl1(input byte_t v);
        return {v[6:0], v[7]};
    endfunction

    function automatic byte_t rotl2(input byte_t v);
        return {v[5:0], v[7:6]};
    endfunction

    function automatic byte_t rotl3(input byte_t v);
        return {v[4:0], v[7:5]};
    endfunction

    function automatic byte_t rotl4(input byte_t v);
        return {v[3:0], v[7:4]};
    endfunction

    function automatic byte_t rotl6(input byte_t v);
        return {v[1:0], v[7:2]};
    endfunction

    byte_t inv_val;
    byte_t pre_affine;

    generate
        if (INV) begin : g_inverse
            // Undo the affine map first, then invert in the field.
            always_comb begin
                inv_val    = 8'h00;
                pre_affine = rotl1(i_byte) ^ rotl3(i_byte) ^ rotl6(i_byte) ^ 8'h05;
                inv_val    = gf_inv(pre_affine);
                o_byte     = inv_val;
            end
        end else begin : g_forward
            // Field inverse, then b ^ rotl(b,1..4) ^ 0x63.
            always_comb begin
                pre_affine = 8'h00;
                inv_val    = gf_inv(i_byte);
                o_byte     = inv_val ^ rotl1(inv_val) ^ rotl2(inv_val)
                           ^ rotl3(inv_val) ^ rotl4(inv_val) ^ 8'h63;
            end
        end
    endgenerate

endmodule : aes_sbox

// File: rtl/subshift_serializer.sv
// ----------------------------------------------------------------------------
// subshift_serializer
//  Round front-end: captures a 128-bit state, applies SubBytes + ShiftRows
//  (or the inverses when INV=1) and streams it as four 32-bit columns, one per
//  accepted beat. Four S-boxes are time-shared across the columns.
//  Ports:
//   clk           in   1    clock
//   rst           in   1    asynchronous active-low reset
//   i_valid       in   1    upstream state valid
//   o_ready       out  1    a state is accepted this cycle
//   i_state       in   128  byte k = i_state[127-8k -: 8]
//   i_last_round  in   1    tag captured with i_state
//   o_valid       out  1    o_column valid
//   i_ready       in   1    downstream accepts o_column
//   o_column      out  32   {row0,row1,row2,row3} of column o_col_idx
//   o_col_idx     out  2    column index 0..3
//   o_last_col    out  1    final column of the block
//   o_last_round  out  1    captured tag, stable across the block
// ----------------------------------------------------------------------------
module subshift_serializer
    import aes_pkg::*;
#(
    parameter bit INV = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_state,
    input  logic         i_last_round,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [31:0]  o_column,
    output logic [1:0]   o_col_idx,
    output logic         o_last_col,
    output logic         o_last_round
);

    ser_state_e state_reg, state_next;
    logic [1:0] idx_reg, idx_next;
    state_t     buf_reg, buf_next;
    logic       tag_reg, tag_next;

    logic       ready_int;
    logic       capture;
    logic       emitting;

    byte_t      buf_bytes [16];
    byte_t      col_bytes [4];

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            buf_reg   <= '0;
            tag_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            buf_reg   <= buf_next;
            tag_reg   <= tag_next;
        end
    end

    // Ready in IDLE, or on the final beat when it is being consumed, so the
    // next block starts on the very next cycle with no bubble.
    assign emitting  = (state_reg == EMIT);
    assign ready_int = (state_reg == IDLE) || (emitting && (idx_reg == 2'd3) && i_ready);
    assign capture   = i_valid && ready_int;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        buf_next   = buf_reg;
        tag_next   = tag_reg;

        case (state_reg)
            IDLE: begin
                if (capture) begin
                    state_next = EMIT;
                    idx_next   = 2'd0;
                    buf_next   = i_state;
                    tag_next   = i_last_round;
                end
            end

            EMIT: begin
                if (i_ready) begin
                    if (idx_reg != 2'd3) begin
                        idx_next = idx_reg + 2'd1;
                    end else if (capture) begin
                        state_next = EMIT;
                        idx_next   = 2'd0;
                        buf_next   = i_state;
                        tag_next   = i_last_round;
                    end else begin
                        state_next = IDLE;
                        idx_next   = 2'd0;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                idx_next   = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output column: byte select by the ShiftRows map, then the S-boxes.
    // Everything here depends only on registered buf/idx.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            assign buf_bytes[gi] = buf_reg[127-8*gi -: 8];
        end

        for (gi = 0; gi < 4; gi++) begin : g_row
            logic [3:0] src;
            byte_t      sb_in;
            byte_t      sb_out;

            assign src   = sr_src(idx_reg, 2'(gi), INV);
            assign sb_in = buf_bytes[src];

            aes_sbox #(.INV(INV)) u_sbox (
                .i_byte (sb_in),
                .o_byte (sb_out)
            );

            assign col_bytes[gi] = sb_out;
        end
    endgenerate

    assign o_ready      = ready_int;
    assign o_valid      = emitting;
    assign o_column     = emitting ? {col_bytes[0], col_bytes[1], col_bytes[2], col_bytes[3]} : 32'h0;
    assign o_col_idx    = idx_reg;
    assign o_last_col   = emitting && (idx_reg == 2'd3);
    assign o_last_round = tag_reg;

endmodule : subshift_serializer

// File: tb/tb_subshift_serializer.sv
// ----------------------------------------------------------------------------
// tb_subshift_serializer
//  Scoreboard bench: the stimulus side pushes the expected beats of each block
//  when the block is handed over; per-DUT monitors compare every presented beat
//  against the head of the queue (popping on accept, checking hold on stall).
//  u_enc uses INV=0, u_dec uses INV=1.
// ----------------------------------------------------------------------------
module tb_subshift_serializer;

    typedef struct {
        logic [31:0] col;
        logic [1:0]  idx;
        logic        tag;
    } exp_t;

    logic         clk;
    logic         rst;

    logic         valid0, ready_in0, tag_in0;
    logic [127:0] state0;
    logic         o_ready0, o_valid0, o_last_col0, o_last_round0;
    logic [31:0]  o_column0;
    logic [1:0]   o_col_idx0;

    logic         valid1, ready_in1, tag_in1;
    logic [127:0] state1;
    logic         o_ready1, o_valid1, o_last_col1, o_last_round1;
    logic [31:0]  o_column1;
    logic [1:0]   o_col_idx1;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int passes = 0;
    int beats0 = 0;

    subshift_serializer #(.INV(1'b0)) u_enc (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (valid0),
        .o_ready      (o_ready0),
        .i_state      (state0),
        .i_last_round (tag_in0),
        .o_valid      (o_valid0),
        .i_ready      (ready_in0),
        .o_column     (o_column0),
        .o_col_idx    (o_col_idx0),
        .o_last_col   (o_last_col0),
        .o_last_round (o_last_round0)
    );

    subshift_serializer #(.INV(1'b1)) u_dec (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (valid1),
        .o_ready      (o_ready1),
        .i_state      (state1),
        .i_last_round (tag_in1),
        .o_valid      (o_valid1),
        .i_ready      (ready_in1),
        .o_column     (o_column1),
        .o_col_idx    (o_col_idx1),
        .o_last_col   (o_last_col1),
        .o_last_round (o_last_round1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One monitor step for DUT sel, run on the falling edge.
    task automatic mon(input int sel);
        logic        v, rdy_in, rdy_out, lc, lr;
        logic [31:0] col;
        logic [1:0]  idx;
        exp_t        e;
        int          qs;
        if (sel == 0) begin
            v = o_valid0; rdy_in = ready_in0; rdy_out = o_ready0;
            lc = o_last_col0; lr = o_last_round0; col = o_column0; idx = o_col_idx0;
            qs = q0.size();
        end else begin
            v = o_valid1; rdy_in = ready_in1; rdy_out = o_ready1;
            lc = o_last_col1; lr = o_last_round1; col = o_column1; idx = o_col_idx1;
            qs = q1.size();
        end
        if (!v) return;
        if (qs == 0) begin
            if (rdy_in) begin
                checks++;
                $display("FAIL unexpected_beat dut%0d: got col %08h idx %0d, expected no beat", sel, col, idx);
            end
            return;
        end
        e = (sel == 0) ? q0[0] : q1[0];
        chk($sformatf("column dut%0d", sel), col, e.col);
        chk($sformatf("col_idx dut%0d", sel), 32'(idx), 32'(e.idx));
        chk($sformatf("last_col dut%0d", sel), 32'(lc), 32'(e.idx == 2'd3));
        chk($sformatf("last_round dut%0d", sel), 32'(lr), 32'(e.tag));
        if (!rdy_in) begin
            chk($sformatf("stall_o_ready dut%0d", sel), 32'(rdy_out), 32'd0);
        end else begin
            $display("beat dut%0d idx %0d col %08h tag %0d", sel, idx, col, lr);
            if (sel == 0) begin
                void'(q0.pop_front());
                beats0++;
            end else begin
                void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) if (rst) mon(0);
    always @(negedge clk) if (rst) mon(1);

    // Hand one state to DUT sel; expected beats are queued once the handshake
    // is guaranteed (o_ready seen high with i_valid asserted, before the edge).
    // Entered and left at posedge + 1.
    task automatic send(input int sel, input logic [127:0] st, input logic tag,
                        input logic [31:0] c0, input logic [31:0] c1,
                        input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0] cols [4];
        int          n;
        logic        rdy;
        cols = '{c0, c1, c2, c3};
        if (sel == 0) begin state0 = st; tag_in0 = tag; valid0 = 1'b1; end
        else          begin state1 = st; tag_in1 = tag; valid1 = 1'b1; end
        n = 0;
        while (1) begin
            @(negedge clk);
            rdy = (sel == 0) ? o_ready0 : o_ready1;
            if (rdy) begin
                for (int k = 0; k < 4; k++) begin
                    exp_t e;
                    e.col = cols[k];
                    e.idx = 2'(k);
                    e.tag = tag;
                    if (sel == 0) q0.push_back(e); else q1.push_back(e);
                end
                break;
            end
            n++;
            if (n > 20) begin
                checks++;
                $display("FAIL send_timeout dut%0d: o_ready stayed 0, expected 1 within 20 cycles", sel);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (sel == 0) valid0 = 1'b0; else valid1 = 1'b0;
        $display("sent dut%0d state %032h tag %0d", sel, st, tag);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] CNT_IN   = 128'h000102030405060708090a0b0c0d0e0f;

    int start_beats;

    initial begin
        rst = 1'b0;
        valid0 = 1'b0; ready_in0 = 1'b1; tag_in0 = 1'b0; state0 = '0;
        valid1 = 1'b0; ready_in1 = 1'b1; tag_in1 = 1'b0; state1 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", 32'(o_valid0), 32'd0);
        chk("rst_o_column", o_column0, 32'h0);
        chk("rst_o_col_idx", 32'(o_col_idx0), 32'd0);
        chk("rst_o_last_col", 32'(o_last_col0), 32'd0);
        chk("rst_o_last_round", 32'(o_last_round0), 32'd0);
        chk("rst_o_valid_dec", 32'(o_valid1), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_o_ready", 32'(o_ready0), 32'd1);
        chk("post_rst_o_ready_dec", 32'(o_ready1), 32'd1);

        // Forward FIPS-197 vector
        send(0, FIPS_IN, 1'b0, 32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
        repeat (6) @(posedge clk);
        #1;

        // Inverse vector
        send(1, FIPS_OUT, 1'b1, 32'h193de3be, 32'ha0f4e22b, 32'h9ac68d2a, 32'he9f84808);
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: 3 stalled cycles while idx=1 is on the bus
        send(0, FIPS_IN, 1'b1, 32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
        @(posedge clk);
        #1 ready_in0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_in0 = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back: second state offered during the idx=3 beat
        send(0, FIPS_IN, 1'b0, 32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
        start_beats = beats0;
        repeat (3) @(posedge clk);
        #1;
        send(0, CNT_IN, 1'b1, 32'h636b6776, 32'hf201ab7b, 32'h30d777c5, 32'hfe7c6f2b);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_contiguous_beats", 32'(beats0 - start_beats), 32'd8);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-block at idx=2
        send(0, FIPS_IN, 1'b1, 32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_idx", 32'(o_col_idx0), 32'd2);
        rst = 1'b0;
        #1;
        chk("midrst_o_valid", 32'(o_valid0), 32'd0);
        chk("midrst_o_column", o_column0, 32'h0);
        chk("midrst_o_col_idx", 32'(o_col_idx0), 32'd0);
        chk("midrst_o_last_round", 32'(o_last_round0), 32'd0);
        q0.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_release_o_ready", 32'(o_ready0), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_partial", 32'(o_valid0), 32'd0);
        end
        @(posedge clk);
        #1;

        chk("q_enc_drained", 32'(q0.size()), 32'd0);
        chk("q_dec_drained", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_subshift_serializer
